// File: rtl/victory_tracker.sv
// Round/match referee for the crossy-roads board: a frog holding GOAL_ROW for
// HOLD_CYCLES consecutive enabled cycles wins the round; WIN_SCORE wins the match.
module victory_tracker #(
    parameter int NUM_PLAYERS = 2,
    parameter int ROW_W       = 4,
    parameter int GOAL_ROW    = 0,
    parameter int HOLD_CYCLES = 1,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 3,
    parameter int PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [NUM_PLAYERS*ROW_W-1:0]   frog_row,
    input  logic                           round_ack,
    input  logic                           new_match,
    output logic [NUM_PLAYERS-1:0]         win_pulse,
    output logic                           round_over,
    output logic [PID_W-1:0]               winner_id,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic                           match_over,
    output logic [1:0]                     dbg_state
);

    localparam int                 CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]   HOLD_MAX  = HOLD_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0]   HOLD_QUAL = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ROW_W-1:0]   GOAL_VAL  = GOAL_ROW[ROW_W-1:0];
    localparam logic [SCORE_W-1:0] WIN_VAL   = WIN_SCORE[SCORE_W-1:0];

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_ROUND_WON = 2'd1,
        ST_MATCH_WON = 2'd2
    } state_t;

    state_t                           r_state;
    state_t                           w_next_state;
    logic [CNT_W-1:0]                 r_hold [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]           r_win_pulse;
    logic                             r_round_over;
    logic [PID_W-1:0]                 r_winner_id;
    logic [NUM_PLAYERS*SCORE_W-1:0]   r_scores;
    logic                             r_match_over;

    logic [NUM_PLAYERS-1:0]           w_on_goal;
    logic [NUM_PLAYERS-1:0]           w_qual;
    logic                             w_any_qual;
    logic [PID_W-1:0]                 w_winner;
    logic [SCORE_W-1:0]               w_cur_score;
    logic [SCORE_W-1:0]               w_next_score;

    always_comb begin
        w_on_goal = '0;
        w_qual    = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_on_goal[i] = enable && (frog_row[i*ROW_W +: ROW_W] == GOAL_VAL);
            w_qual[i]    = w_on_goal[i] && (r_hold[i] == HOLD_QUAL) && (r_state == ST_PLAY);
        end
    end

    // Descending scan leaves the lowest-index qualifier as the winner on ties.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (w_qual[i]) w_winner = PID_W'(i);
        end
    end

    assign w_any_qual   = |w_qual;
    assign w_cur_score  = r_scores[int'(w_winner)*SCORE_W +: SCORE_W];
    assign w_next_score = (w_cur_score == '1) ? w_cur_score : w_cur_score + SCORE_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_PLAY;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (new_match) begin
            w_next_state = ST_PLAY;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_any_qual)
                        w_next_state = (w_next_score == WIN_VAL) ? ST_MATCH_WON : ST_ROUND_WON;
                end
                ST_ROUND_WON: begin
                    if (round_ack) w_next_state = ST_PLAY;
                end
                ST_MATCH_WON: w_next_state = ST_MATCH_WON;
                default:      w_next_state = ST_PLAY;
            endcase
        end
    end

    // Counters only run in PLAY; any qualification leaves PLAY and clears them all.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PLAYERS; i++) r_hold[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (new_match || w_any_qual || !w_on_goal[i] || (r_state != ST_PLAY))
                    r_hold[i] <= '0;
                else if (r_hold[i] != HOLD_MAX)
                    r_hold[i] <= r_hold[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win_pulse  <= '0;
            r_round_over <= 1'b0;
            r_winner_id  <= '0;
            r_scores     <= '0;
            r_match_over <= 1'b0;
        end else begin
            r_win_pulse <= '0;
            if (new_match) begin
                r_round_over <= 1'b0;
                r_winner_id  <= '0;
                r_scores     <= '0;
                r_match_over <= 1'b0;
            end else if (w_any_qual) begin
                r_winner_id  <= w_winner;
                r_win_pulse  <= NUM_PLAYERS'(1) << w_winner;
                r_scores[int'(w_winner)*SCORE_W +: SCORE_W] <= w_next_score;
                r_round_over <= 1'b1;
                if (w_next_score == WIN_VAL) r_match_over <= 1'b1;
            end else if ((r_state == ST_ROUND_WON) && round_ack) begin
                r_round_over <= 1'b0;
            end
        end
    end

    assign win_pulse  = r_win_pulse;
    assign round_over = r_round_over;
    assign winner_id  = r_winner_id;
    assign scores     = r_scores;
    assign match_over = r_match_over;
    assign dbg_state  = r_state;

endmodule

// File: doc/victory_tracker.md
# victory_tracker

Multi-player round and match referee for the crossy-roads LED board. Watches each player's frog row and declares a round win when a frog holds the goal row for a programmable number of consecutive cycles. Keeps a saturating per-player score and declares a match winner at a target score. Sits between the per-player frog movement logic and the display/game-control FSM, and supersedes the single-player registered goal-row check.

## Interface
Parameters:
- NUM_PLAYERS, 2: number of frogs tracked (1..8).
- ROW_W, 4: frog row width (16-row board).
- GOAL_ROW, 0: row value that counts as reaching the far side.
- HOLD_CYCLES, 1: consecutive goal-row cycles required to qualify (>=1).
- SCORE_W, 4: per-player score width.
- WIN_SCORE, 3: score that ends the match (1..2^SCORE_W-1).
- PID_W, max(1, clog2(NUM_PLAYERS)): derived player-index width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  game running; low freezes qualification and clears hold counters.
- frog_row  in  NUM_PLAYERS*ROW_W  packed rows, player i at [i*ROW_W +: ROW_W].
- round_ack  in  1  game control acknowledges round end; resumes play.
- new_match  in  1  clears scores and all state; starts a fresh match.
- win_pulse  out  NUM_PLAYERS  one-hot, one-cycle pulse on the round winner's bit.
- round_over  out  1  level: a round winner is latched.
- winner_id  out  PID_W  index of latest round winner (match winner once match_over).
- scores  out  NUM_PLAYERS*SCORE_W  packed scores, same layout as frog_row.
- match_over  out  1  level: some player reached WIN_SCORE.

## Operation
- States: PLAY, ROUND_WON, MATCH_WON. Reset state is PLAY.
- Per-player hold counter, sized to count to HOLD_CYCLES:
  - In PLAY with enable=1 and the player's row equal to GOAL_ROW: increment, saturating.
  - Otherwise: clear to 0.
  - All counters clear on any exit from PLAY.
- A player qualifies in the cycle where it is on GOAL_ROW, enable=1, and the counter equals HOLD_CYCLES-1.
- On qualification (PLAY, at least one qualifier), the registered update is:
  - winner = lowest-index qualifier; only that player scores on ties.
  - winner_id <= winner; win_pulse[winner] <= 1 for exactly one cycle.
  - score[winner] <= score+1, saturating at 2^SCORE_W-1.
  - round_over <= 1.
  - Next state is MATCH_WON if the new score == WIN_SCORE, else ROUND_WON.
- ROUND_WON:
  - frog_row and enable are ignored; outputs are held.
  - round_ack=1 -> PLAY next cycle, round_over <= 0. Scores and winner_id are retained.
- MATCH_WON:
  - match_over=1, round_over=1; round_ack is ignored.
  - Only new_match exits.
- new_match in any state:
  - scores, counters, win_pulse, round_over, match_over and winner_id all go to 0; state -> PLAY.
  - new_match has priority over a same-cycle qualification or round_ack.
- round_ack in PLAY is ignored.

## Timing
- Reset values: win_pulse=0, round_over=0, winner_id=0, scores=0, match_over=0, counters=0, state=PLAY.
- Reset is asynchronous on assertion. Mid-round reset discards partial hold counts.
- Latency: the first goal-row cycle is edge k. With frog_row held steady, outputs change after edge k+HOLD_CYCLES-1 and are visible for HOLD_CYCLES cycles after the first goal cycle.
- HOLD_CYCLES=1 gives a single registered cycle, equivalent to the legacy check.
- Any non-goal sample, or enable=0, restarts the count.
- win_pulse is never asserted in two consecutive cycles; at most one bit is set.
- After round_ack, PLAY resumes on the following edge with counters at 0. A frog still sitting on GOAL_ROW needs a full HOLD_CYCLES again.

## Test plan
- Reset: assert reset_n=0 mid-run with state non-zero -> all outputs 0 immediately, without waiting for a clk edge; state PLAY.
- NUM_PLAYERS=2, HOLD_CYCLES=3: player1 row 0 for 2 cycles, then row 5, then row 0 for 3 cycles -> no pulse after the first 2 cycles. On the 3rd goal cycle: win_pulse=2'b10 for one cycle, scores[1]=1, winner_id=1, round_over=1.
- Tie: both players reach row 0 on the same cycle (HOLD_CYCLES=1) -> winner_id=0, win_pulse=2'b01, scores = {0,1}.
- ROUND_WON: hold round_ack=0 and toggle frog rows -> nothing changes. Pulse round_ack -> round_over=0 next cycle; a frog still on row 0 wins again only after HOLD_CYCLES cycles.
- WIN_SCORE=3: player0 wins 3 rounds -> match_over=1 after the 3rd, winner_id=0, round_ack ignored. Then new_match -> scores 0, match_over=0, PLAY.
- enable=0 while player0 sits on row 0 for 10 cycles -> no win. Raise enable -> win exactly HOLD_CYCLES cycles later. new_match issued in the same cycle as a qualification -> no score change.
